aq_djpeg_byte_window: RTL and testbench
=======================================

Name: aq_djpeg_byte_window

Overview:
- Upstream feeder of the JPEG header-parsing FSM.
- Accepts a 32-bit AXI4-Stream of raw JPEG bytes and buffers them.
- Presents an MSB-first, byte-aligned 32-bit window (DataIn) to the FSM. The FSM sees each byte exactly once.
- Each cycle the window advances by 1 byte (UseByte) or 2 bytes (UseWord). It flags DataInEnd once the final stream byte has been consumed.

Parameters:
- BYTE_SWAP, 1: when 1, the first JPEG byte of a beat is s_tdata[7:0]; when 0, it is s_tdata[31:24].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- Clear  in  1  synchronous flush; empties the buffer and clears the end flag
- s_tdata  in  32  stream data
- s_tkeep  in  4  byte enables; contiguous from the first byte; values other than 4'hF allowed only with s_tlast
- s_tvalid  in  1  stream valid
- s_tlast  in  1  last beat of the JPEG file
- s_tready  out  1  stream ready
- DataIn  out  32  window; oldest byte in [31:24]
- DataInEnable  out  1  window holds valid data
- DataInEnd  out  1  end of file reached and buffer empty
- UseByte  in  1  consume 1 byte
- UseWord  in  1  consume 2 bytes
- Level  out  4  buffered byte count, 0..8

Behaviour:
- Storage is a 64-bit byte shift buffer plus a 4-bit count (0..8) and an end_seen flag. All are registers.
- Reset values:
  - count=0, buffer=0, end_seen=0.
  - Outputs: DataIn=0, DataInEnable=0, DataInEnd=0, Level=0.
  - s_tready=1 after reset.
- DataIn is the top 4 buffer bytes. Slots at or beyond count read as 8'h00.
- DataInEnable = (count>=4) | (end_seen & count>=1). It is combinational from registers only.
- Consumption amount:
  - consumed = 2 if UseWord, else 1 if UseByte, else 0. UseWord wins if both are asserted.
  - Use inputs are honoured only while DataInEnable=1.
  - consumed is clipped to count (padding bytes are never counted).
- Acceptance:
  - s_tready = (count<=4) & ~end_seen & ~Clear. It depends on registers only, with no path from the Use inputs.
  - A beat is accepted when s_tvalid & s_tready.
  - nbytes = number of set s_tkeep bits (1..4); on non-last beats nbytes=4.
- Per-edge update:
  - Buffer is shifted left by consumed bytes.
  - Accepted bytes are appended at byte slot (count-consumed), in stream order per BYTE_SWAP.
  - count <= count - consumed + nbytes. The result never exceeds 8.
  - Simultaneous consume and accept in the same cycle is legal and must be lossless.
- Latency: a byte accepted at edge n is visible on DataIn after edge n, i.e. 1 cycle.
- End of stream:
  - An accepted beat with s_tlast sets end_seen. s_tready stays 0 until Clear.
  - DataInEnd = end_seen & (count==0). It stays high until Clear.
  - Beats with s_tkeep=0 are not accepted and are a protocol violation. Behaviour is undefined and there is no check.
- Clear:
  - At the next edge: count=0, buffer=0, end_seen=0.
  - Clear has priority over consume and accept in the same cycle; a beat offered in that cycle is not taken because s_tready=0.
- Asynchronous reset mid-transfer drops all buffered bytes. The upstream must restart from the beginning of the file.

Test Plan:
- Byte order: BYTE_SWAP=1; beats 32'hE0FFD8FF then 32'h104A0000, no Use -> DataIn=32'hFFD8FFE0, DataInEnable=1, count=8, s_tready=0.
- Word consume: from the state above, UseWord for 1 cycle -> DataIn=32'hFFE00000, count=6, s_tready=0. A second UseWord -> DataIn=32'h00004A10, count=4, s_tready=1.
- Mixed streaming: 64 random beats; FSM model issues random UseByte/UseWord, with consume and accept in the same cycles -> consumed byte sequence equals the input byte sequence exactly, with no loss or duplication.
- Partial last beat: final beat s_tkeep=4'b0011 bytes 8'hFF,8'hD9, buffer otherwise empty -> DataIn=32'hFFD90000, DataInEnable=1. After UseWord -> count=0, DataInEnable=0, DataInEnd=1.
- UseWord while count=1 at end -> count=0, no underflow; DataInEnd=1 on the next cycle.
- Clear and reset: Clear with count=5 and end_seen=1 -> count=0, DataInEnd=0, s_tready=1 next cycle. rst low mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/aq_djpeg_byte_window.sv
// rtl/aq_djpeg_byte_window.sv - 32-bit AXI-Stream to byte-aligned 32-bit window for the JPEG header FSM
// Eight-byte shift buffer; the oldest byte always sits in the top slot.
module aq_djpeg_byte_window #(
    parameter bit BYTE_SWAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Clear,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tkeep,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [31:0] DataIn,
    output logic        DataInEnable,
    output logic        DataInEnd,
    input  logic        UseByte,
    input  logic        UseWord,
    output logic [3:0]  Level
);

    logic [63:0] byteBuf;
    logic [3:0]  count;
    logic        endSeen;

    logic [3:0]  useAmt;
    logic [3:0]  consumed;
    logic [3:0]  nbytes;
    logic [3:0]  base;
    logic        accept;
    logic [31:0] lanes;
    logic [31:0] ordered;
    logic [63:0] shifted;
    logic [63:0] appended;

    assign DataInEnable = (count >= 4'd4) | (endSeen & (count != 4'd0));
    assign DataInEnd    = endSeen & (count == 4'd0);
    assign s_tready     = (count <= 4'd4) & ~endSeen & ~Clear;
    assign Level        = count;
    assign accept       = s_tvalid & s_tready;

    // Slots past the fill level are forced to zero so the FSM never sees stale bytes.
    always_comb begin
        DataIn = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (4'(i) < count) begin
                DataIn[31 - 8*i -: 8] = byteBuf[63 - 8*i -: 8];
            end
        end
    end

    always_comb begin
        useAmt = 4'd0;
        if (UseWord) begin
            useAmt = 4'd2;
        end else if (UseByte) begin
            useAmt = 4'd1;
        end
        consumed = 4'd0;
        if (DataInEnable) begin
            consumed = (useAmt > count) ? count : useAmt;
        end
    end

    // Non-last beats always carry four bytes; only the last beat honours tkeep.
    always_comb begin
        lanes = s_tdata;
        nbytes = 4'd4;
        if (s_tlast) begin
            for (int i = 0; i < 4; i++) begin
                if (!s_tkeep[i]) begin
                    lanes[8*i +: 8] = 8'h00;
                end
            end
            nbytes = {3'b000, s_tkeep[0]} + {3'b000, s_tkeep[1]}
                   + {3'b000, s_tkeep[2]} + {3'b000, s_tkeep[3]};
        end
        if (BYTE_SWAP) begin
            ordered = {lanes[7:0], lanes[15:8], lanes[23:16], lanes[31:24]};
        end else begin
            ordered = lanes;
        end
    end

    always_comb begin
        base     = count - consumed;
        shifted  = byteBuf << {consumed, 3'b000};
        appended = {ordered, 32'h0} >> {base, 3'b000};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteBuf <= 64'h0;
            count   <= 4'd0;
            endSeen <= 1'b0;
        end else if (Clear) begin
            byteBuf <= 64'h0;
            count   <= 4'd0;
            endSeen <= 1'b0;
        end else begin
            if (accept) begin
                byteBuf <= shifted | appended;
                count   <= base + nbytes;
                if (s_tlast) begin
                    endSeen <= 1'b1;
                end
            end else begin
                byteBuf <= shifted;
                count   <= base;
            end
        end
    end

endmodule

// File: tb/tb_aq_djpeg_byte_window.sv
// tb/tb_aq_djpeg_byte_window.sv - vector table plus scoreboard bench for aq_djpeg_byte_window
module tb_aq_djpeg_byte_window;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] s_tdata = 32'h0;
    logic [3:0]  s_tkeep = 4'h0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] DataIn;
    logic        DataInEnable;
    logic        DataInEnd;
    logic        UseByte = 1'b0;
    logic        UseWord = 1'b0;
    logic [3:0]  Level;

    int checks = 0;
    int errors = 0;

    aq_djpeg_byte_window #(.BYTE_SWAP(1'b1)) dut (
        .clk(clk), .rst(rst), .Clear(Clear),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .DataIn(DataIn), .DataInEnable(DataInEnable),
        .DataInEnd(DataInEnd), .UseByte(UseByte), .UseWord(UseWord), .Level(Level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        valid;
        logic        last;
        logic        ub;
        logic        uw;
        logic        clr;
        logic [31:0] eData;
        logic        eEn;
        logic        eEnd;
        logic [3:0]  eLvl;
        logic        eRdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic [3:0] k, input logic v,
                                input logic l, input logic ub, input logic uw, input logic c,
                                input logic [31:0] ed, input logic een, input logic eend,
                                input logic [3:0] elvl, input logic erdy);
        vec_t r;
        r.data = d; r.keep = k; r.valid = v; r.last = l; r.ub = ub; r.uw = uw; r.clr = c;
        r.eData = ed; r.eEn = een; r.eEnd = eend; r.eLvl = elvl; r.eRdy = erdy;
        return r;
    endfunction

    task automatic idle_inputs();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 4'h0; s_tdata = 32'h0;
        UseByte = 1'b0; UseWord = 1'b0; Clear = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] d, input logic en,
                                 input logic e, input logic [3:0] lvl, input logic rdy);
        chk({tag, ".DataIn"}, DataIn, d);
        chk({tag, ".DataInEnable"}, {31'h0, DataInEnable}, {31'h0, en});
        chk({tag, ".DataInEnd"}, {31'h0, DataInEnd}, {31'h0, e});
        chk({tag, ".Level"}, {28'h0, Level}, {28'h0, lvl});
        chk({tag, ".s_tready"}, {31'h0, s_tready}, {31'h0, rdy});
    endtask

    logic [7:0]  q[$];
    logic [31:0] beats[64];
    logic [3:0]  lastKeep;

    initial begin
        // Rows are sequential cycles: inputs held for one edge, outputs checked after it.
        vecs.push_back(mk(32'hE0FFD8FF, 4'hF, 1, 0, 0, 0, 0, 32'hFFD8FFE0, 1, 0, 4'd4, 1));
        vecs.push_back(mk(32'h104A0000, 4'hF, 1, 0, 0, 0, 0, 32'hFFD8FFE0, 1, 0, 4'd8, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hFFD8FFE0, 1, 0, 4'd8, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 1, 0, 32'hFFE00000, 1, 0, 4'd6, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 1, 0, 32'h00004A10, 1, 0, 4'd4, 1));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 1, 1, 0, 32'h4A100000, 0, 0, 4'd2, 1));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 1, 0, 32'h4A100000, 0, 0, 4'd2, 1));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h00000000, 0, 0, 4'd0, 1));
        vecs.push_back(mk(32'hABCDD9FF, 4'h3, 1, 1, 0, 0, 0, 32'hFFD90000, 1, 0, 4'd2, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 1, 0, 32'h00000000, 0, 1, 4'd0, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h00000000, 0, 1, 4'd0, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h00000000, 0, 0, 4'd0, 1));
        vecs.push_back(mk(32'h12345677, 4'h1, 1, 1, 0, 0, 0, 32'h77000000, 1, 0, 4'd1, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 1, 0, 32'h00000000, 0, 1, 4'd0, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h00000000, 0, 0, 4'd0, 1));
        vecs.push_back(mk(32'h11223344, 4'hF, 1, 0, 0, 0, 0, 32'h44332211, 1, 0, 4'd4, 1));
        vecs.push_back(mk(32'h00000055, 4'h1, 1, 1, 0, 0, 0, 32'h44332211, 1, 0, 4'd5, 0));
        vecs.push_back(mk(32'hCAFEF00D, 4'hF, 1, 0, 1, 0, 1, 32'h00000000, 0, 0, 4'd0, 1));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0, 4'd0, 1));
        vecs.push_back(mk(32'hAABBCCDD, 4'hF, 1, 0, 0, 0, 0, 32'hDDCCBBAA, 1, 0, 4'd4, 1));
        vecs.push_back(mk(32'h01020304, 4'hF, 1, 0, 1, 0, 0, 32'hCCBBAA04, 1, 0, 4'd7, 0));
        vecs.push_back(mk(32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h00000000, 0, 0, 4'd0, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 32'h0, 0, 0, 4'd0, 1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("post_reset", 32'h0, 0, 0, 4'd0, 1);

        foreach (vecs[i]) begin
            s_tdata = vecs[i].data; s_tkeep = vecs[i].keep; s_tvalid = vecs[i].valid;
            s_tlast = vecs[i].last; UseByte = vecs[i].ub; UseWord = vecs[i].uw;
            Clear = vecs[i].clr;
            @(posedge clk);
            #1 idle_inputs();
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].eData, vecs[i].eEn,
                          vecs[i].eEnd, vecs[i].eLvl, vecs[i].eRdy);
        end

        // Asynchronous reset mid-stream
        s_tdata = 32'h89ABCDEF; s_tkeep = 4'hF; s_tvalid = 1'b1;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        chk("pre_async.Level", {28'h0, Level}, 32'd4);
        #2 rst = 1'b0;
        #1 check_outputs("async_rst", 32'h0, 0, 0, 4'd0, 1);
        @(negedge clk);
        rst = 1'b1;

        // Random streaming against a byte-queue scoreboard
        foreach (beats[i]) beats[i] = $urandom;
        lastKeep = 4'(({1'b0, 4'b0001} << $urandom_range(1, 4)) - 5'd1);
        begin
            int  beatIdx = 0;
            int  pushed = 0;
            int  popped = 0;
            bit  endModel = 0;
            bit  done = 0;
            for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
                int nb;
                int cons;
                bit en;
                bit rdy;
                logic [31:0] win;
                @(negedge clk);
                en  = (q.size() >= 4) || (endModel && q.size() >= 1);
                rdy = (q.size() <= 4) && !endModel;
                win = 32'h0;
                for (int k = 0; k < 4; k++) if (k < q.size()) win[31 - 8*k -: 8] = q[k];
                chk("rnd.DataIn", DataIn, win);
                chk("rnd.Level", {28'h0, Level}, 32'(q.size()));
                chk("rnd.DataInEnable", {31'h0, DataInEnable}, {31'h0, en});
                chk("rnd.s_tready", {31'h0, s_tready}, {31'h0, rdy});
                if (endModel && q.size() == 0) begin
                    chk("rnd.DataInEnd", {31'h0, DataInEnd}, 32'd1);
                    done = 1;
                end else begin
                    s_tvalid = (beatIdx < 64) && ($urandom_range(0, 3) != 0);
                    s_tdata  = (beatIdx < 64) ? beats[beatIdx] : 32'h0;
                    s_tlast  = (beatIdx == 63);
                    s_tkeep  = (beatIdx == 63) ? lastKeep : 4'hF;
                    UseWord  = ($urandom_range(0, 2) == 0);
                    UseByte  = ($urandom_range(0, 1) == 0);
                    cons = UseWord ? 2 : (UseByte ? 1 : 0);
                    if (!en) cons = 0;
                    if (cons > q.size()) cons = q.size();
                    nb = 0;
                    if (s_tvalid && rdy) nb = s_tlast ? $countones(s_tkeep) : 4;
                    @(posedge clk);
                    for (int k = 0; k < cons; k++) begin
                        void'(q.pop_front());
                        popped++;
                    end
                    for (int k = 0; k < nb; k++) begin
                        q.push_back(beats[beatIdx][8*k +: 8]);
                        pushed++;
                    end
                    if (nb > 0) begin
                        if (beatIdx == 63) endModel = 1;
                        beatIdx++;
                    end
                end
            end
            idle_inputs();
            chk("rnd.completed", {31'h0, done}, 32'd1);
            chk("rnd.byte_balance", popped, pushed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
